fetch: RTL and testbench

Instruction fetch stage sitting directly upstream of the instruction memory (`imem`). It owns the program counter, issues word addresses to `imem`, captures the returned instruction words, and hands {pc, instruction} pairs to decode through a 2-entry buffer with a valid/ready handshake. A redirect input from execute (branch/jump) flushes in-flight and buffered work and restarts fetch at the new address.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_if.sv | 26 ++
 rtl/fetch_buffer.sv | 62 ++++++
 rtl/fetch.sv | 79 +++++++
 tb/tb_fetch.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, the buffered {pc, instruction} entry type and PC helpers
// for the instruction fetch stage.
package fetch_pkg;

  localparam int ADDR_SIZE  = 31;
  localparam int INSTR_SIZE = 31;

  typedef logic [ADDR_SIZE:0]  addr_t;
  typedef logic [INSTR_SIZE:0] instr_t;

  localparam addr_t PC_STEP = addr_t'(4);

  typedef struct packed {
    addr_t  pc;
    instr_t instr;
  } fetch_entry_t;

  localparam int ENTRY_WIDTH = $bits(fetch_entry_t);

  // Redirect targets may carry junk in the byte-offset bits; fetch is word-based.
  function automatic addr_t alignPc(input addr_t a);
    return {a[ADDR_SIZE:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Groups the imem request/response, execute redirect and decode handshake
// signals of the fetch stage; master is the fetch side.
interface fetch_if;
  import fetch_pkg::*;

  addr_t  imem_addr;
  logic   imem_enable;
  instr_t imem_data;
  logic   redirect_valid;
  addr_t  redirect_pc;
  logic   out_valid;
  logic   out_ready;
  addr_t  out_pc;
  instr_t out_instr;

  modport master (
    output imem_addr, imem_enable, out_valid, out_pc, out_instr,
    input  imem_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, imem_enable, out_valid, out_pc, out_instr,
    output imem_data, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry synchronous FIFO holding fetched {pc, instruction} pairs; entry 0
// is always the head so the outputs come straight from a register.
module fetch_buffer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic [1:0]       o_count,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_entry0;
  logic [WIDTH-1:0] r_entry1;
  logic [1:0]       r_count;
  logic             w_pop;
  logic             w_push;

  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  // Flush only drops the count; stale entry contents are never exposed as valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_entry0 <= '0;
      r_entry1 <= '0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_entry0 <= i_data;
          else                 r_entry1 <= i_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_entry0 <= r_entry1;
          r_count  <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd2) begin
            r_entry0 <= r_entry1;
            r_entry1 <= i_data;
          end else begin
            r_entry0 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head  = r_entry0;
  assign o_count = r_count;
  assign o_valid = (r_count != 2'd0);

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, issues one-cycle-latency imem reads under
// a credit check against the 2-entry output buffer, and restarts on redirect.
module fetch
  import fetch_pkg::*;
#(
  parameter addr_t RESET_PC = '0
) (
  input logic     clk,
  input logic     reset,
  fetch_if.master bus
);

  addr_t        r_pc;
  addr_t        r_inflightPc;
  logic         r_inflight;

  logic         w_redirect;
  addr_t        w_redirectPc;
  logic [1:0]   w_count;
  logic         w_bufValid;
  logic         w_pop;
  logic         w_push;
  logic [2:0]   w_used;
  logic         w_issue;
  fetch_entry_t w_pushEntry;
  fetch_entry_t w_head;

  assign w_redirect   = bus.redirect_valid && !reset;
  assign w_redirectPc = alignPc(bus.redirect_pc);

  assign bus.out_valid = w_bufValid && !w_redirect && !reset;
  assign w_pop         = bus.out_valid && bus.out_ready;
  assign w_push        = r_inflight && !w_redirect;

  // Credits: buffered + in flight - leaving this cycle must leave room for one more.
  assign w_used  = {1'b0, w_count} + {2'b00, r_inflight};
  assign w_issue = !reset && (w_redirect || (w_used < (3'd2 + {2'b00, w_pop})));

  assign bus.imem_enable = w_issue;
  assign bus.imem_addr   = w_redirect ? w_redirectPc : r_pc;

  assign w_pushEntry = '{pc: r_inflightPc, instr: bus.imem_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_inflight   <= 1'b0;
      r_inflightPc <= '0;
    end else if (w_redirect) begin
      r_pc         <= w_redirectPc + PC_STEP;
      r_inflight   <= 1'b1;
      r_inflightPc <= w_redirectPc;
    end else if (w_issue) begin
      r_pc         <= r_pc + PC_STEP;
      r_inflight   <= 1'b1;
      r_inflightPc <= r_pc;
    end else begin
      r_inflight   <= 1'b0;
    end
  end

  fetch_buffer #(
    .WIDTH(ENTRY_WIDTH)
  ) u_buffer (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .i_data  (w_pushEntry),
    .o_head  (w_head),
    .o_count (w_count),
    .o_valid (w_bufValid)
  );

  assign bus.out_pc    = w_head.pc;
  assign bus.out_instr = w_head.instr;

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: one-cycle imem responder, directed startup/stall/redirect/wrap
// sequences and randomized traffic, with accepted instructions scoreboarded in order.
module tb_fetch;
  import fetch_pkg::*;

  localparam logic [31:0] RESET0     = 32'h0000_0000;
  localparam logic [31:0] RESETW     = 32'hFFFF_FFFC;
  localparam int          STREAM_LEN = 512;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic    clk = 1'b0;
  logic    reset;
  fetch_if bus();
  fetch_if busW();

  exp_t expQ[$];
  exp_t monExp;
  int   checks  = 0;
  int   passes  = 0;
  int   idle    = 0;
  int   maxIdle = 0;
  int   r;
  logic [31:0] tgt;

  fetch #(.RESET_PC(RESET0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  fetch #(.RESET_PC(RESETW)) dutWrap (
    .clk   (clk),
    .reset (reset),
    .bus   (busW)
  );

  always #5 clk = ~clk;

  // Program image: the word at byte address a holds a/4.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  // One-cycle imem; poisoned data whenever no fetch was issued.
  always @(posedge clk) begin
    bus.imem_data  <= bus.imem_enable  ? memWord(bus.imem_addr)  : 32'hDEAD_BEEF;
    busW.imem_data <= busW.imem_enable ? memWord(busW.imem_addr) : 32'hDEAD_BEEF;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Decode sees a strictly sequential word stream from every restart point.
  task automatic restartStream(input logic [31:0] start);
    logic [31:0] a;
    expQ.delete();
    a = {start[31:2], 2'b00};
    for (int i = 0; i < STREAM_LEN; i++) begin
      expQ.push_back('{pc: a, instr: memWord(a)});
      a = a + 32'd4;
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic rdv,
                               input logic [31:0] rdpc, input logic rdy);
    reset              = rst;
    bus.redirect_valid = rdv;
    bus.redirect_pc    = rdpc;
    bus.out_ready      = rdy;
    if (rst)      restartStream(RESET0);
    else if (rdv) restartStream(rdpc);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic startupRun(input string tag);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      case (c)
        0: begin
          checkOutput({tag, " c0 imem_enable"}, {31'b0, bus.imem_enable}, 32'd1);
          checkOutput({tag, " c0 imem_addr"}, bus.imem_addr, RESET0);
          checkOutput({tag, " c0 out_valid"}, {31'b0, bus.out_valid}, 32'd0);
        end
        1: checkOutput({tag, " c1 out_valid"}, {31'b0, bus.out_valid}, 32'd0);
        2: begin
          checkOutput({tag, " c2 out_valid"}, {31'b0, bus.out_valid}, 32'd1);
          checkOutput({tag, " c2 out_pc"}, bus.out_pc, RESET0);
        end
        default: checkOutput({tag, " c3 out_pc"}, bus.out_pc, RESET0 + 32'd4);
      endcase
      nextCycle();
    end
  endtask

  // Monitor: scoreboard every accepted instruction and track output bubbles.
  always @(negedge clk) begin
    if (reset || bus.redirect_valid || bus.out_valid) idle = 0;
    else begin
      idle++;
      if (idle > maxIdle) maxIdle = idle;
    end
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        $display("[TB] FAIL scoreboard: got an accepted instruction, expected none pending");
      end else begin
        monExp = expQ.pop_front();
        checkOutput("stream out_pc", bus.out_pc, monExp.pc);
        checkOutput("stream out_instr", bus.out_instr, monExp.instr);
      end
    end
  end

  initial begin
    busW.redirect_valid = 1'b0;
    busW.redirect_pc    = 32'h0;
    busW.out_ready      = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    nextCycle();
    nextCycle();

    @(negedge clk);
    checkOutput("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("reset imem_enable", {31'b0, bus.imem_enable}, 32'd0);
    checkOutput("reset imem_addr", bus.imem_addr, RESET0);
    checkOutput("reset out_pc", bus.out_pc, 32'h0);
    checkOutput("reset out_instr", bus.out_instr, 32'h0);
    checkOutput("reset wrap imem_addr", busW.imem_addr, RESETW);
    nextCycle();

    // Startup, back-pressure in cycles 3..7, and the wrap instance alongside.
    for (int c = 0; c < 14; c++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, !(c >= 3 && c <= 7));
      @(negedge clk);
      case (c)
        0: begin
          checkOutput("s1 c0 imem_enable", {31'b0, bus.imem_enable}, 32'd1);
          checkOutput("s1 c0 imem_addr", bus.imem_addr, 32'h0);
          checkOutput("s1 c0 out_valid", {31'b0, bus.out_valid}, 32'd0);
          checkOutput("wrap c0 imem_addr", busW.imem_addr, RESETW);
        end
        1: begin
          checkOutput("s1 c1 out_valid", {31'b0, bus.out_valid}, 32'd0);
          checkOutput("wrap c1 imem_enable", {31'b0, busW.imem_enable}, 32'd1);
          checkOutput("wrap c1 imem_addr", busW.imem_addr, 32'h0);
        end
        2: begin
          checkOutput("s1 c2 out_valid", {31'b0, bus.out_valid}, 32'd1);
          checkOutput("s1 c2 out_pc", bus.out_pc, 32'h0);
          checkOutput("s1 c2 out_instr", bus.out_instr, 32'h0);
          checkOutput("wrap c2 out_pc", busW.out_pc, RESETW);
          checkOutput("wrap c2 out_instr", busW.out_instr, 32'h3FFF_FFFF);
        end
        3: begin
          checkOutput("s1 c3 imem_enable", {31'b0, bus.imem_enable}, 32'd0);
          checkOutput("wrap c3 out_valid", {31'b0, busW.out_valid}, 32'd1);
          checkOutput("wrap c3 out_pc", busW.out_pc, 32'h0);
        end
        4, 5, 6, 7: begin
          checkOutput("s1 stall imem_enable", {31'b0, bus.imem_enable}, 32'd0);
          checkOutput("s1 stall out_pc", bus.out_pc, 32'h4);
        end
        8: begin
          checkOutput("s1 c8 imem_enable", {31'b0, bus.imem_enable}, 32'd1);
          checkOutput("s1 c8 out_pc", bus.out_pc, 32'h4);
        end
        10: checkOutput("s1 c10 out_pc", bus.out_pc, 32'hC);
        default: ;
      endcase
      nextCycle();
    end

    // Fresh start, fill the buffer, redirect while full, then an unaligned redirect.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    nextCycle();
    for (int c = 0; c < 15; c++) begin
      if (c == 6)       applyStimulus(1'b0, 1'b1, 32'h0000_0040, 1'b1);
      else if (c == 10) applyStimulus(1'b0, 1'b1, 32'h0000_0103, 1'b1);
      else              applyStimulus(1'b0, 1'b0, 32'h0, !(c >= 3 && c <= 5));
      @(negedge clk);
      case (c)
        5: checkOutput("s2 full imem_enable", {31'b0, bus.imem_enable}, 32'd0);
        6: begin
          checkOutput("s2 redirect out_valid", {31'b0, bus.out_valid}, 32'd0);
          checkOutput("s2 redirect imem_enable", {31'b0, bus.imem_enable}, 32'd1);
          checkOutput("s2 redirect imem_addr", bus.imem_addr, 32'h40);
        end
        7:  checkOutput("s2 R+1 out_valid", {31'b0, bus.out_valid}, 32'd0);
        8: begin
          checkOutput("s2 R+2 out_valid", {31'b0, bus.out_valid}, 32'd1);
          checkOutput("s2 R+2 out_pc", bus.out_pc, 32'h40);
          checkOutput("s2 R+2 out_instr", bus.out_instr, 32'h10);
        end
        9:  checkOutput("s2 R+3 out_pc", bus.out_pc, 32'h44);
        10: begin
          checkOutput("s3 unaligned imem_addr", bus.imem_addr, 32'h100);
          checkOutput("s3 unaligned out_valid", {31'b0, bus.out_valid}, 32'd0);
        end
        12: checkOutput("s3 R+2 out_pc", bus.out_pc, 32'h100);
        13: checkOutput("s3 R+3 out_pc", bus.out_pc, 32'h104);
        default: ;
      endcase
      nextCycle();
    end

    // Reset with a full buffer must restart exactly like power-up.
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("s4 full before reset", {31'b0, bus.out_valid}, 32'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    nextCycle();
    startupRun("s4");

    for (int i = 0; i < 400; i++) begin
      r   = $urandom_range(0, 99);
      tgt = ($urandom_range(0, 1) == 1) ? $urandom : (32'hFFFF_FFE0 | ($urandom & 32'h1F));
      if (r < 2)       applyStimulus(1'b1, 1'b0, tgt, 1'b1);
      else if (r < 10) applyStimulus(1'b0, 1'b1, tgt, $urandom_range(0, 3) != 0);
      else             applyStimulus(1'b0, 1'b0, tgt, $urandom_range(0, 3) != 0);
      nextCycle();
    end

    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      nextCycle();
    end

    checks++;
    if (maxIdle <= 2) passes++;
    else $display("[TB] FAIL max output bubble: got %0d cycles, expected at most 2", maxIdle);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
